bw_mul_pipe: RTL and testbench

//   Parametrised, pipelined signed fixed-point Baugh-Wooley multiplier with a valid/ready handshake.

---
 rtl/bw_mul_pkg.sv | 26 ++
 rtl/bw_mul_pipe_if.sv | 32 +++
 rtl/bw_pp_gen.sv | 36 +++
 rtl/bw_mul_pipe.sv | 175 +++++++++++++++++
 tb/tb_bw_mul_pipe.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bw_mul_pkg.sv
// Shared Q-format helpers and mode encodings for the pipelined Baugh-Wooley multiplier.
package bw_mul_pkg;

    // Rounding applied before the fractional shift.
    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } rnd_mode_e;

    // Behaviour when the shifted product does not fit the result width.
    typedef enum logic {
        SAT_WRAP  = 1'b0,
        SAT_CLAMP = 1'b1
    } sat_mode_e;

    // Largest two's complement value representable in w bits.
    function automatic longint q_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest two's complement value representable in w bits.
    function automatic longint q_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/bw_mul_pipe_if.sv
// Operand and result handshake bundle for bw_mul_pipe.
//
// Handshake: each side uses strict valid/ready. A beat moves when valid and
// ready are both high at a rising clock edge. A producer never withdraws or
// alters a beat while valid is high and ready is low; ready may depend
// combinationally on the consumer side (in_ready follows out_ready).
interface bw_mul_pipe_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_rnd;
    logic             in_sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_p;
    logic             out_ovf;

    // Operand producer / result consumer side.
    modport master (
        output in_valid, in_a, in_b, in_rnd, in_sat, out_ready,
        input  in_ready, out_valid, out_p, out_ovf
    );

    // Multiplier side.
    modport slave (
        input  in_valid, in_a, in_b, in_rnd, in_sat, out_ready,
        output in_ready, out_valid, out_p, out_ovf
    );
endinterface

// File: rtl/bw_pp_gen.sv
// Baugh-Wooley partial-product matrix for a signed WIDTH x WIDTH multiply.
// Each row is already shifted into its 2*WIDTH-bit column position. Terms
// that mix one sign bit with one magnitude bit are inverted, and the
// correction constant 2^WIDTH + 2^(2*WIDTH-1) restores the signed result
// modulo 2^(2*WIDTH) once every row and the correction are summed.
module bw_pp_gen #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    output logic [WIDTH-1:0][2*WIDTH-1:0]     rows,
    output logic [2*WIDTH-1:0]                corr
);

    // Build every AND term and invert the sign/magnitude cross terms.
    always_comb begin
        rows = '0;
        for (int j = 0; j < WIDTH; j++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((i == WIDTH - 1) != (j == WIDTH - 1)) begin
                    rows[j][i + j] = ~(a[i] & b[j]);
                end else begin
                    rows[j][i + j] = a[i] & b[j];
                end
            end
        end
    end

    // Constant correction bits that cancel the inverted-term offset.
    always_comb begin
        corr                = '0;
        corr[WIDTH]         = 1'b1;
        corr[2*WIDTH - 1]   = 1'b1;
    end

endmodule

// File: rtl/bw_mul_pipe.sv
// Three-stage pipelined signed Qm.FRAC multiplier. S1 registers operands,
// S2 registers a carry-save (sum/carry) reduction of the Baugh-Wooley
// matrix, S3 registers the rounded, shifted and range-checked product.
// All stages share one enable, so a stalled result freezes the whole pipe
// and bubbles stay where they are.
module bw_mul_pipe
    import bw_mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    bw_mul_pipe_if.slave bus,
    output logic [2:0]  dbg_valid
);

    localparam int PW = 2 * WIDTH;
    localparam int RW = 2 * WIDTH + 1;

    localparam logic signed [RW-1:0] MAX_S = RW'(q_max(WIDTH));
    localparam logic signed [RW-1:0] MIN_S = RW'(q_min(WIDTH));
    localparam logic [WIDTH-1:0]     MAX_W = WIDTH'(q_max(WIDTH));
    localparam logic [WIDTH-1:0]     MIN_W = WIDTH'(q_min(WIDTH));

    // Stage 1 state
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    rnd_mode_e        rnd1_q, rnd1_d;
    sat_mode_e        sat1_q, sat1_d;

    // Stage 2 state
    logic             v2_q, v2_d;
    logic [PW-1:0]    sum_q, sum_d;
    logic [PW-1:0]    carry_q, carry_d;
    rnd_mode_e        rnd2_q, rnd2_d;
    sat_mode_e        sat2_q, sat2_d;

    // Stage 3 (output) state
    logic             v3_q, v3_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             ovf_q, ovf_d;

    logic                        adv;
    logic [WIDTH-1:0][PW-1:0]    pp_rows;
    logic [PW-1:0]               pp_corr;
    logic [PW-1:0]               cs_sum;
    logic [PW-1:0]               cs_carry;
    logic [PW-1:0]               full;
    logic signed [RW-1:0]        f_ext;
    logic signed [RW-1:0]        rnd_add;
    logic signed [RW-1:0]        r_val;
    logic signed [RW-1:0]        s_val;
    logic                        ovf_n;
    logic [WIDTH-1:0]            p_n;

    bw_pp_gen #(
        .WIDTH (WIDTH)
    ) u_pp_gen (
        .a    (a_q),
        .b    (b_q),
        .rows (pp_rows),
        .corr (pp_corr)
    );

    // Carry-save reduction of the matrix into a sum/carry pair.
    always_comb begin
        logic [PW-1:0] t_sum;
        logic [PW-1:0] t_carry;
        cs_sum   = pp_corr;
        cs_carry = '0;
        for (int r = 0; r < WIDTH; r++) begin
            t_sum    = cs_sum ^ cs_carry ^ pp_rows[r];
            t_carry  = ((cs_sum & cs_carry) | (cs_sum & pp_rows[r]) |
                        (cs_carry & pp_rows[r])) << 1;
            cs_sum   = t_sum;
            cs_carry = t_carry;
        end
    end

    // Final add, optional half-up rounding, arithmetic shift and range clamp.
    always_comb begin
        full    = sum_q + carry_q;
        f_ext   = {full[PW-1], full};
        rnd_add = (rnd2_q == RND_HALF_UP) ? (RW'(1) << (FRAC - 1)) : '0;
        r_val   = f_ext + rnd_add;
        s_val   = r_val >>> FRAC;
        ovf_n   = (s_val > MAX_S) || (s_val < MIN_S);
        if (ovf_n && (sat2_q == SAT_CLAMP)) begin
            p_n = s_val[RW-1] ? MIN_W : MAX_W;
        end else begin
            p_n = s_val[WIDTH-1:0];
        end
    end

    // Global pipeline enable and next-state for every stage.
    always_comb begin
        adv     = !v3_q || bus.out_ready;
        v1_d    = v1_q;
        a_d     = a_q;
        b_d     = b_q;
        rnd1_d  = rnd1_q;
        sat1_d  = sat1_q;
        v2_d    = v2_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        rnd2_d  = rnd2_q;
        sat2_d  = sat2_q;
        v3_d    = v3_q;
        p_d     = p_q;
        ovf_d   = ovf_q;
        if (adv) begin
            v1_d = bus.in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
            if (bus.in_valid) begin
                a_d    = bus.in_a;
                b_d    = bus.in_b;
                rnd1_d = rnd_mode_e'(bus.in_rnd);
                sat1_d = sat_mode_e'(bus.in_sat);
            end
            if (v1_q) begin
                sum_d   = cs_sum;
                carry_d = cs_carry;
                rnd2_d  = rnd1_q;
                sat2_d  = sat1_q;
            end
            if (v2_q) begin
                p_d   = p_n;
                ovf_d = ovf_n;
            end
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rnd1_q  <= RND_TRUNC;
            sat1_q  <= SAT_WRAP;
            v2_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            rnd2_q  <= RND_TRUNC;
            sat2_q  <= SAT_WRAP;
            v3_q    <= 1'b0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rnd1_q  <= rnd1_d;
            sat1_q  <= sat1_d;
            v2_q    <= v2_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            rnd2_q  <= rnd2_d;
            sat2_q  <= sat2_d;
            v3_q    <= v3_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = v3_q;
    assign bus.out_p     = p_q;
    assign bus.out_ovf   = ovf_q;
    assign dbg_valid     = {v3_q, v2_q, v1_q};

endmodule

// File: tb/tb_bw_mul_pipe.sv
// Bench for bw_mul_pipe: directed vector table (Q3.12 and Q0.15 instances),
// stalled stream, reset with beats in flight, and a randomized stream
// scored against a plain-arithmetic reference model.
module tb_bw_mul_pipe;

    logic clk;
    logic rst_n;
    logic [2:0] dbg12;
    logic [2:0] dbg15;

    bw_mul_pipe_if #(.WIDTH(16)) bus ();
    bw_mul_pipe_if #(.WIDTH(16)) bus15 ();

    bw_mul_pipe #(.WIDTH(16), .FRAC(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_valid (dbg12)
    );

    bw_mul_pipe #(.WIDTH(16), .FRAC(15)) dut15 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus15),
        .dbg_valid (dbg15)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the test finished");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    logic [16:0] exp_q[$];
    bit          prev_stall = 1'b0;
    logic [15:0] prev_p;
    logic        prev_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: exact product, optional +half LSB, floor shift, range clamp.
    function automatic logic [16:0] model(input int frac, input logic [15:0] a, input logic [15:0] b,
                                          input bit rnd, input bit sat);
        longint sa, sb, r, s;
        logic [15:0] p;
        bit ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = sa * sb;
        if (rnd) r = r + (longint'(1) <<< (frac - 1));
        s = r >>> frac;
        ovf = (s > 32767) || (s < -32768);
        if (ovf && sat) p = (s < 0) ? 16'h8000 : 16'h7FFF;
        else            p = 16'(s);
        return {ovf, p};
    endfunction

    function automatic logic [15:0] pick();
        if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 6))
                0: return 16'h0000;
                1: return 16'h8000;
                2: return 16'h7FFF;
                3: return 16'hFFFF;
                4: return 16'h0001;
                5: return 16'h1000;
                default: return 16'hF000;
            endcase
        end
        return 16'($urandom());
    endfunction

    // Driver: one beat into an empty pipe, wait (bounded) for its result.
    task automatic apply_single(input bit use15, input logic [15:0] a, input logic [15:0] b,
                                input bit rnd, input bit sat,
                                output logic [15:0] p, output logic ovf, output int lat);
        bit ov;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus15.out_ready = 1'b1;
        if (use15) begin
            bus15.in_valid = 1'b1; bus15.in_a = a; bus15.in_b = b; bus15.in_rnd = rnd; bus15.in_sat = sat;
        end else begin
            bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_rnd = rnd; bus.in_sat = sat;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus15.in_valid = 1'b0;
        lat = 1;
        ov = use15 ? bus15.out_valid : bus.out_valid;
        while (!ov && lat < 20) begin
            @(negedge clk);
            lat++;
            ov = use15 ? bus15.out_valid : bus.out_valid;
        end
        p   = use15 ? bus15.out_p   : bus.out_p;
        ovf = use15 ? bus15.out_ovf : bus.out_ovf;
    endtask

    // Driver + monitor for one clock of the FRAC=12 instance.
    task automatic cycle_step(input bit drv, input logic [15:0] a, input logic [15:0] b,
                              input bit rnd, input bit sat, input bit ordy, output bit acc);
        logic [16:0] e;
        @(negedge clk);
        bus.in_valid  = drv;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_rnd    = rnd;
        bus.in_sat    = sat;
        bus.out_ready = ordy;
        #1;
        check("in_ready_rule", bus.in_ready, !bus.out_valid || ordy);
        if (prev_stall) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_p", bus.out_p, prev_p);
            check("hold_ovf", bus.out_ovf, prev_ovf);
        end
        if (bus.out_valid && ordy) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", bus.out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_p", bus.out_p, e[15:0]);
                check("out_ovf", bus.out_ovf, e[16]);
            end
        end
        acc = drv && bus.in_ready;
        if (acc) exp_q.push_back(model(12, a, b, rnd, sat));
        prev_stall = bus.out_valid && !ordy;
        prev_p     = bus.out_p;
        prev_ovf   = bus.out_ovf;
    endtask

    typedef struct {
        bit          f15;
        logic [15:0] a;
        logic [15:0] b;
        bit          rnd;
        bit          sat;
        logic [15:0] ep;
        bit          eovf;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [15:0] p;
        logic        ovf;
        int          lat;
        bit          acc;
        int          sent;
        int          cyc;
        int          seen;
        bit          saw_block;

        vecs[0]  = '{0, 16'h1000, 16'h1000, 0, 1, 16'h1000, 0};
        vecs[1]  = '{0, 16'hF000, 16'h1000, 0, 1, 16'hF000, 0};
        vecs[2]  = '{0, 16'hF000, 16'hF000, 0, 1, 16'h1000, 0};
        vecs[3]  = '{0, 16'h0000, 16'h1010, 0, 1, 16'h0000, 0};
        vecs[4]  = '{0, 16'h0001, 16'h0800, 0, 1, 16'h0000, 0};
        vecs[5]  = '{0, 16'h0001, 16'h0800, 1, 1, 16'h0001, 0};
        vecs[6]  = '{0, 16'hFFFF, 16'h0800, 1, 1, 16'h0000, 0};
        vecs[7]  = '{0, 16'hFFFF, 16'h0800, 0, 1, 16'hFFFF, 0};
        vecs[8]  = '{0, 16'h7FFF, 16'h7FFF, 0, 1, 16'h7FFF, 1};
        vecs[9]  = '{0, 16'h7FFF, 16'h7FFF, 0, 0, 16'hFFF0, 1};
        vecs[10] = '{0, 16'h8000, 16'h8000, 0, 0, 16'h0000, 1};
        vecs[11] = '{0, 16'h8000, 16'h7FFF, 0, 1, 16'h8000, 1};
        vecs[12] = '{1, 16'h8000, 16'h8000, 0, 1, 16'h7FFF, 1};
        vecs[13] = '{1, 16'h8000, 16'h7FFF, 0, 1, 16'h8001, 0};
        vecs[14] = '{1, 16'h4000, 16'h4000, 0, 1, 16'h2000, 0};
        vecs[15] = '{1, 16'h8000, 16'h8000, 0, 0, 16'h8000, 1};

        // Reset
        rst_n = 1'b0;
        bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_b = '0;  bus.in_rnd = 1'b0;  bus.in_sat = 1'b0;
        bus.out_ready = 1'b0;
        bus15.in_valid = 1'b0; bus15.in_a = '0; bus15.in_b = '0; bus15.in_rnd = 1'b0; bus15.in_sat = 1'b0;
        bus15.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_p", bus.out_p, 0);
        check("rst_out_ovf", bus.out_ovf, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Directed vector table
        foreach (vecs[i]) begin
            apply_single(vecs[i].f15, vecs[i].a, vecs[i].b, vecs[i].rnd, vecs[i].sat, p, ovf, lat);
            check($sformatf("vec%0d_lat", i), lat, 3);
            check($sformatf("vec%0d_p", i), p, vecs[i].ep);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].eovf);
        end
        @(negedge clk);

        // Back-to-back stream of 8 beats, consumer stalls for 4 cycles mid-stream
        prev_stall = 1'b0;
        n_out = 0;
        sent = 0;
        cyc = 0;
        saw_block = 1'b0;
        while ((sent < 8 || exp_q.size() > 0) && cyc < 200) begin
            cycle_step(sent < 8, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom()),
                       !(cyc >= 5 && cyc < 9), acc);
            if (bus.out_valid && !bus.out_ready && !bus.in_ready) saw_block = 1'b1;
            if (acc) sent++;
            cyc++;
        end
        check("stream_count", n_out, 8);
        check("stream_backpressure_seen", saw_block, 1);

        // Reset with two beats in flight
        cycle_step(1, 16'h1000, 16'h3000, 0, 1, 1, acc);
        cycle_step(1, 16'h2000, 16'h3000, 0, 1, 1, acc);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("inflight_rst_valid", bus.out_valid, 0);
        check("inflight_rst_p", bus.out_p, 0);
        check("inflight_rst_ovf", bus.out_ovf, 0);
        exp_q.delete();
        prev_stall = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            cycle_step(0, '0, '0, 0, 0, 1, acc);
            if (bus.out_valid) seen++;
        end
        check("no_stale_result", seen, 0);
        apply_single(0, 16'h1000, 16'h2000, 0, 1, p, ovf, lat);
        check("post_rst_lat", lat, 3);
        check("post_rst_p", p, 16'h2000);
        check("post_rst_ovf", ovf, 0);
        @(negedge clk);

        // Randomized stream against the reference model
        prev_stall = 1'b0;
        n_out = 0;
        sent = 0;
        cyc = 0;
        while ((sent < 10000 || exp_q.size() > 0) && cyc < 60000) begin
            cycle_step((sent < 10000) && ($urandom_range(0, 9) < 8), pick(), pick(),
                       1'($urandom()), 1'($urandom()), $urandom_range(0, 9) < 6, acc);
            if (acc) sent++;
            cyc++;
        end
        check("rand_sent", sent, 10000);
        check("rand_received", n_out, 10000);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
